// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//
// Shares the configuration register bus among NUM_REQ requesters. One
// requester is granted at a time in round-robin order; its direction,
// address and write data are latched onto the bus and held with sel_en
// until the decoders' OR-combined ack arrives, or until TIMEOUT cycles pass.
// The access then finishes with a one-cycle done pulse (err=1 on timeout),
// and a one-cycle release gap follows before the next select.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         per-requester request level, held until done
//   req_wr      per-requester direction (1 write, 0 read)
//   req_addr    packed addresses, requester i at [i*W_WIDTH +: W_WIDTH]
//   req_wdata   packed write data, same packing
//   done        one-cycle completion pulse to the granted requester
//   err         qualifies done: 1 means the access timed out
//   rsp_rdata   read data, valid with done, held until the next completion
//   sel_en      bus select to the register decoders
//   wr_rd_s     bus direction (1 write, 0 read)
//   addr        bus address
//   wdata       bus write data
//   ack_in      OR of all decoder acks
//   rd_data_in  OR of all decoder read data
module reg_access_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int W_WIDTH = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           req_wr,
   input  logic [NUM_REQ*W_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*W_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]           done,
   output logic                         err,
   output logic [W_WIDTH-1:0]           rsp_rdata,
   output logic                         sel_en,
   output logic                         wr_rd_s,
   output logic [W_WIDTH-1:0]           addr,
   output logic [W_WIDTH-1:0]           wdata,
   input  logic                         ack_in,
   input  logic [W_WIDTH-1:0]           rd_data_in
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACCESS  = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   // Pointer starts at the last index so requester 0 wins the first grant.
   localparam logic [GW-1:0] LAST_GNT_RST = GW'(NUM_REQ - 1);
   localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);

   logic [1:0]          state_q,     state_d;
   logic [GW-1:0]       last_gnt_q,  last_gnt_d;
   logic [GW-1:0]       gnt_q,       gnt_d;
   logic [TW-1:0]       tmo_cnt_q,   tmo_cnt_d;
   logic                sel_en_q,    sel_en_d;
   logic                wr_rd_s_q,   wr_rd_s_d;
   logic [W_WIDTH-1:0]  addr_q,      addr_d;
   logic [W_WIDTH-1:0]  wdata_q,     wdata_d;
   logic [NUM_REQ-1:0]  done_q,      done_d;
   logic                err_q,       err_d;
   logic [W_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;

   logic [W_WIDTH-1:0]  addr_arr  [NUM_REQ];
   logic [W_WIDTH-1:0]  wdata_arr [NUM_REQ];

   logic                pick_vld;
   logic [GW-1:0]       pick_idx;
   int                  cand;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*W_WIDTH +: W_WIDTH];
      assign wdata_arr[g] = req_wdata[g*W_WIDTH +: W_WIDTH];
   end

   // First active request strictly after the last grant, wrapping around.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last_gnt_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!pick_vld && req[GW'(cand)]) begin
            pick_vld = 1'b1;
            pick_idx = GW'(cand);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      gnt_d       = gnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      sel_en_d    = sel_en_q;
      wr_rd_s_d   = wr_rd_s_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      done_d      = '0;
      err_d       = 1'b0;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         S_IDLE: begin
            sel_en_d = 1'b0;
            if (pick_vld) begin
               gnt_d      = pick_idx;
               last_gnt_d = pick_idx;
               wr_rd_s_d  = req_wr[pick_idx];
               addr_d     = addr_arr[pick_idx];
               wdata_d    = wdata_arr[pick_idx];
               sel_en_d   = 1'b1;
               tmo_cnt_d  = '0;
               state_d    = S_ACCESS;
            end
         end

         S_ACCESS: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // Ack is tested first so an ack on the final timeout cycle wins.
            if (ack_in) begin
               done_d[gnt_q] = 1'b1;
               rsp_rdata_d   = wr_rd_s_q ? '0 : rd_data_in;
               sel_en_d      = 1'b0;
               tmo_cnt_d     = '0;
               state_d       = S_RELEASE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               done_d[gnt_q] = 1'b1;
               err_d         = 1'b1;
               rsp_rdata_d   = '0;
               sel_en_d      = 1'b0;
               tmo_cnt_d     = '0;
               state_d       = S_RELEASE;
            end
         end

         // Gap cycle lets the decoder's registered ack drop before reselect.
         S_RELEASE: begin
            sel_en_d = 1'b0;
            state_d  = S_IDLE;
         end

         default: begin
            sel_en_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         last_gnt_q  <= LAST_GNT_RST;
         gnt_q       <= '0;
         tmo_cnt_q   <= '0;
         sel_en_q    <= 1'b0;
         wr_rd_s_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         gnt_q       <= gnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         sel_en_q    <= sel_en_d;
         wr_rd_s_q   <= wr_rd_s_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign done      = done_q;
   assign err       = err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign sel_en    = sel_en_q;
   assign wr_rd_s   = wr_rd_s_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Testbench for reg_access_arbiter: a register-decoder model answers the
// bus with address-dependent latency, and a transaction-level timeline model
// predicts every output cycle by cycle.
module tb_reg_access_arbiter;

   localparam int N = 2;
   localparam int T = 16;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req, req_wr;
   logic [15:0] req_addr, req_wdata;
   logic [1:0]  done;
   logic        err;
   logic [7:0]  rsp_rdata;
   logic        sel_en, wr_rd_s;
   logic [7:0]  addr, wdata;
   logic        ack_in;
   logic [7:0]  rd_data_in;

   logic        r_arr [N];
   logic        w_arr [N];
   logic [7:0]  a_arr [N];
   logic [7:0]  d_arr [N];

   assign req       = {r_arr[1], r_arr[0]};
   assign req_wr    = {w_arr[1], w_arr[0]};
   assign req_addr  = {a_arr[1], a_arr[0]};
   assign req_wdata = {d_arr[1], d_arr[0]};

   reg_access_arbiter #(.NUM_REQ(N), .W_WIDTH(8), .TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .err(err),
      .rsp_rdata(rsp_rdata), .sel_en(sel_en), .wr_rd_s(wr_rd_s),
      .addr(addr), .wdata(wdata), .ack_in(ack_in), .rd_data_in(rd_data_in)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Address map: 0x00-0x0F ack after 1 cycle of select, 0x10-0x1E ack
   // after 1..15 cycles, 0x1F and above unmapped.
   function automatic int lat_of(input logic [7:0] a);
      if (a < 8'h10) return 1;
      return int'(a) - 15;
   endfunction

   function automatic bit mapped(input logic [7:0] a);
      return a < 8'h1F;
   endfunction

   // Register decoder model with registered ack and read data.
   logic [7:0] dmem [32];
   logic [4:0] dcnt;
   logic       dack;
   logic [7:0] drd;
   assign ack_in     = dack;
   assign rd_data_in = drd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dack <= 1'b0;
         drd  <= 8'h00;
         dcnt <= 5'd0;
         for (int i = 0; i < 32; i++) dmem[i] <= 8'h00;
      end else begin
         dack <= 1'b0;
         drd  <= 8'h00;
         if (sel_en && !dack) begin
            if (mapped(addr) && dcnt == 5'(lat_of(addr) - 1)) begin
               dack <= 1'b1;
               dcnt <= 5'd0;
               if (wr_rd_s) dmem[addr[4:0]] <= wdata;
               else         drd <= dmem[addr[4:0]];
            end else begin
               dcnt <= dcnt + 5'd1;
            end
         end else begin
            dcnt <= 5'd0;
         end
      end
   end

   // Timeline model: a granted transaction keeps select for dur cycles,
   // completes on the next, spends one release cycle, then the bus is free.
   logic [7:0] mmem [32];
   int         m_last, m_g, m_age, m_dur;
   bit         m_busy, m_wr, m_terr;
   logic [7:0] m_a, m_wd;
   logic       e_sel, e_err, e_wr;
   logic [1:0] e_done;
   logic [7:0] e_rd, e_addr, e_wd;

   task automatic model_reset();
      m_last = N - 1; m_busy = 0; m_g = 0; m_age = 0; m_dur = 0;
      e_sel = 0; e_err = 0; e_done = 2'b00; e_rd = 8'h00;
      for (int i = 0; i < 32; i++) mmem[i] = 8'h00;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            e_done = 2'b00;
            e_err  = 1'b0;
            if (m_busy) begin
               m_age++;
               if (m_age == m_dur) begin
                  e_sel       = 1'b0;
                  e_done[m_g] = 1'b1;
                  e_err       = m_terr;
                  if (m_terr)    e_rd = 8'h00;
                  else if (m_wr) begin mmem[m_a[4:0]] = m_wd; e_rd = 8'h00; end
                  else           e_rd = mmem[m_a[4:0]];
               end else if (m_age > m_dur + 1) begin
                  m_busy = 0;
               end
            end
            if (!m_busy) begin
               for (int k = 1; k <= N; k++) begin
                  int idx;
                  idx = (m_last + k) % N;
                  if (!m_busy && r_arr[idx]) begin
                     m_busy = 1; m_g = idx; m_last = idx; m_age = 0;
                     m_wr = w_arr[idx]; m_a = a_arr[idx]; m_wd = d_arr[idx];
                     m_terr = !(mapped(m_a) && lat_of(m_a) <= T - 1);
                     m_dur  = m_terr ? T : lat_of(m_a) + 1;
                     e_sel = 1'b1; e_wr = m_wr; e_addr = m_a; e_wd = m_wd;
                  end
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("sel_en", 32'(sel_en), 32'(e_sel));
            check("done", 32'(done), 32'(e_done));
            check("err", 32'(err), 32'(e_err));
            check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
            check("done_onehot", 32'($countones(done) <= 1), 32'd1);
            if (e_sel) begin
               check("wr_rd_s", 32'(wr_rd_s), 32'(e_wr));
               check("addr", 32'(addr), 32'(e_addr));
               check("wdata", 32'(wdata), 32'(e_wd));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One directed access with literal expectations on latency and result.
   task automatic run_single(input string nm, input int i, input bit wr,
                             input logic [7:0] a, input logic [7:0] d,
                             input int exp_sel, input bit exp_err,
                             input logic [7:0] exp_rd);
      int cnt = 0, scnt = 0;
      bit seen = 0;
      @(negedge clk);
      w_arr[i] = wr; a_arr[i] = a; d_arr[i] = d; r_arr[i] = 1'b1;
      while (!seen && cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (sel_en) scnt++;
         if (done[i]) seen = 1;
      end
      r_arr[i] = 1'b0;
      check({nm, "_done_seen"}, 32'(seen), 32'd1);
      check({nm, "_latency"}, 32'(cnt), 32'(exp_sel + 1));
      check({nm, "_sel_cycles"}, 32'(scnt), 32'(exp_sel));
      check({nm, "_err"}, 32'(err), 32'(exp_err));
      check({nm, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
      @(negedge clk);
      check({nm, "_sel_after"}, 32'(sel_en), 32'd0);
      check({nm, "_done_after"}, 32'(done), 32'd0);
   endtask

   task automatic contention();
      int order [4];
      int stamp [4];
      int n = 0, cyc = 0;
      for (int k = 0; k < 4; k++) begin order[k] = -1; stamp[k] = 0; end
      @(negedge clk);
      w_arr[0] = 1; a_arr[0] = 8'h05; d_arr[0] = 8'h11;
      w_arr[1] = 1; a_arr[1] = 8'h06; d_arr[1] = 8'h22;
      r_arr[0] = 1; r_arr[1] = 1;
      while (n < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (done != 2'b00) begin
            order[n] = done[1] ? 1 : 0;
            stamp[n] = cyc;
            n++;
         end
      end
      r_arr[0] = 0; r_arr[1] = 0;
      check("cont_count", 32'(n), 32'd4);
      check("cont_first_latency", 32'(stamp[0]), 32'd3);
      for (int k = 0; k < 4; k++) check($sformatf("cont_order%0d", k), 32'(order[k]), 32'(k % 2));
      for (int k = 1; k < 4; k++) check($sformatf("cont_gap%0d", k), 32'(stamp[k] - stamp[k-1]), 32'd4);
      repeat (4) @(negedge clk);
   endtask

   task automatic reset_mid_access();
      int cnt = 0;
      bit seen = 0;
      @(negedge clk);
      w_arr[0] = 1; a_arr[0] = 8'h04; d_arr[0] = 8'h3C; r_arr[0] = 1;
      @(negedge clk);
      check("rst_sel_granted", 32'(sel_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_sel_low", 32'(sel_en), 32'd0);
      check("rst_done_low", 32'(done), 32'd0);
      check("rst_err_low", 32'(err), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("rst_no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      while (!seen && cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (done[0]) seen = 1;
      end
      r_arr[0] = 0;
      check("rst_regrant_done", 32'(seen), 32'd1);
      check("rst_regrant_latency", 32'(cnt), 32'd3);
      check("rst_regrant_err", 32'(err), 32'd0);
      @(negedge clk);
   endtask

   task automatic agent(input int i, input int ntx);
      for (int t = 0; t < ntx; t++) begin
         int gap, r, cnt;
         bit seen;
         gap = $urandom_range(0, 2);
         if (gap != 0) begin
            r_arr[i] = 1'b0;
            repeat (gap) @(negedge clk);
         end
         r = $urandom_range(0, 7);
         w_arr[i] = 1'($urandom_range(0, 1));
         d_arr[i] = 8'($urandom_range(0, 255));
         if (r < 5)      a_arr[i] = 8'($urandom_range(0, 15));
         else if (r < 7) a_arr[i] = 8'($urandom_range(16, 30));
         else            a_arr[i] = 8'($urandom_range(31, 255));
         r_arr[i] = 1'b1;
         cnt = 0; seen = 0;
         while (!seen && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (done[i]) seen = 1;
         end
         if (!seen) check($sformatf("agent%0d_wait", i), 32'd0, 32'd1);
      end
      r_arr[i] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         r_arr[i] = 0; w_arr[i] = 0; a_arr[i] = 8'h00; d_arr[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      check("reset_sel_en", 32'(sel_en), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_rdata", 32'(rsp_rdata), 32'd0);
      check("reset_addr", 32'(addr), 32'd0);
      check("reset_wr_rd_s", 32'(wr_rd_s), 32'd0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      contention();
      run_single("wr03", 0, 1, 8'h03, 8'hA5, 2, 0, 8'h00);
      run_single("wr02", 1, 1, 8'h02, 8'h5C, 2, 0, 8'h00);
      run_single("rd02", 1, 0, 8'h02, 8'h00, 2, 0, 8'h5C);
      run_single("rd03", 0, 0, 8'h03, 8'h00, 2, 0, 8'hA5);
      run_single("tmo_ff", 0, 0, 8'hFF, 8'h00, T, 1, 8'h00);
      run_single("wr1e", 0, 1, 8'h1E, 8'h77, T, 0, 8'h00);
      run_single("rd1e_lastack", 1, 0, 8'h1E, 8'h00, T, 0, 8'h77);
      reset_mid_access();
      run_single("rd04_after_rst", 1, 0, 8'h04, 8'h00, 2, 0, 8'h3C);

      fork
         agent(0, 40);
         agent(1, 40);
      join
      repeat (6) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
